trap_ctrl: RTL
==============

Name: trap_ctrl

Overview:
- Trap sequencer directly upstream of the CSR file.
- Watches each retiring instruction's exception flags and MRET, and prioritises them into one cause.
- Drives the CSR file's trap-entry/return strobes and operands (exceptionFromInst, mret, mcause_in, mepc_in, mtval_in), then issues a PC redirect to mtvec or mepc.
- Stalls the pipeline while a trap sequence is in flight.

Parameters:
- XLEN, 32, datapath width of PC, instruction, address and CSR values.
- CNT_W, 16, width of the saturating trap-event counter.

Ports:
- clk  in  1  single system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- inst_valid  in  1  instruction at retire stage this cycle.
- pc  in  XLEN  PC of the retiring instruction.
- inst  in  XLEN  raw encoding of the retiring instruction.
- exc_inst_misaligned  in  1  fetch target misaligned.
- exc_illegal  in  1  illegal instruction decoded.
- exc_ebreak  in  1  EBREAK decoded.
- exc_ecall  in  1  ECALL decoded.
- exc_load_misaligned  in  1  misaligned load address.
- exc_store_misaligned  in  1  misaligned store address.
- mem_addr  in  XLEN  effective load/store address.
- mret_req  in  1  MRET decoded.
- nowPrivMode  in  2  current privilege (00 U, 11 M).
- mtvec_in  in  XLEN  current mtvec from the CSR file.
- mepc_cur  in  XLEN  current mepc from the CSR file.
- exceptionFromInst  out  1  one-cycle trap-entry strobe to the CSR file.
- mret  out  1  one-cycle trap-return strobe to the CSR file.
- mcause  out  4  exception code.
- mepc_out  out  XLEN  faulting PC.
- mtval  out  XLEN  trap value.
- stall  out  1  freeze fetch/decode/retire.
- redirect  out  1  one-cycle PC redirect valid.
- redirect_pc  out  XLEN  redirect target.
- trap_count  out  CNT_W  number of trap entries taken, saturating.

Behaviour:
- Reset: state IDLE. All strobes 0, mcause 0, mepc_out 0, mtval 0, redirect_pc 0, stall 0, trap_count 0. Reset asserted mid-sequence aborts it immediately; no partial strobe is emitted.
- States: IDLE, TRAP, TRET, REDIR.
- IDLE, inst_valid=1 with any exception, or mret_req=1 while nowPrivMode!=11:
  - Capture cause, mepc_out=pc and mtval into registers.
  - Next state TRAP.
- IDLE, inst_valid=1, mret_req=1, nowPrivMode=11, no exception: next state TRET.
- IDLE, inst_valid=0: inputs ignored.
- Cause priority, highest first, with mtval:
  - inst_misaligned: cause 0, mtval=pc.
  - illegal, including MRET from U-mode: cause 2, mtval=inst.
  - ebreak: cause 3, mtval=pc.
  - ecall: cause 8 if U-mode, 11 if M-mode; mtval=0.
  - load_misaligned: cause 4, mtval=mem_addr.
  - store_misaligned: cause 6, mtval=mem_addr.
- A simultaneous exception and MRET resolves to the exception; mret is not asserted.
- TRAP: exceptionFromInst=1 for exactly this cycle; mcause, mepc_out and mtval are held stable. trap_count increments unless it equals all-ones. Next state REDIR with target={mtvec_in[XLEN-1:2],2'b00} (direct mode; mode bits ignored).
- TRET: mret=1 for exactly this cycle. Next state REDIR with target=mepc_cur sampled this cycle.
- REDIR: redirect=1 and redirect_pc=target for one cycle. Next state IDLE.
- stall = (state!=IDLE) OR (IDLE AND detection condition), so the detecting instruction's side effects are also frozen.
- Latency: detection at cycle N; CSR strobe at N+1; redirect at N+2; a new instruction is accepted at N+3 at the earliest.
- Strobes and redirect are never high in the same cycle, and never high for two consecutive cycles.
- Registered outputs hold their last value in IDLE.

Decomposition:
- Shared package trap_pkg:
  - exception code constants (EXC_INST_MISALIGN=0, EXC_ILLEGAL=2, EXC_BREAK=3, EXC_LOAD_MISALIGN=4, EXC_STORE_MISALIGN=6, EXC_ECALL_U=8, EXC_ECALL_M=11);
  - privilege constants (UMODE=00, MMODE=11);
  - FSM state encoding.
- One sub-module, trap_prio_enc: combinational priority encoder taking the flags, pc, inst, mem_addr and nowPrivMode, and producing hit, cause and tval. The FSM, capture registers and counter stay in trap_ctrl.

Test Plan:
- Reset asserted during TRAP -> same cycle all outputs 0, state IDLE, trap_count 0; after release, idle with stall=0.
- U-mode ECALL at pc=0x100, mtvec_in=0x0000_0201 -> cycle N+1: exceptionFromInst=1, mcause=8, mepc_out=0x100, mtval=0. Cycle N+2: redirect=1, redirect_pc=0x200. stall=1 for N..N+2.
- exc_illegal and exc_load_misaligned together, inst=0xFFFF_FFFF, mem_addr=0x1003 -> mcause=2, mtval=0xFFFF_FFFF, load cause suppressed.
- M-mode MRET, mepc_cur=0x0000_0404 -> cycle N+1: mret=1, exceptionFromInst=0. Cycle N+2: redirect_pc=0x404.
- U-mode MRET with inst=0x3020_0073 -> treated as illegal: mcause=2, mtval=0x3020_0073, mret never asserted.
- 2^CNT_W+3 back-to-back EBREAKs -> each yields mcause=3, mtval=pc; trap_count saturates at 0xFFFF; next acceptance never earlier than N+3.

Source files
------------

// File: rtl/trap_pkg.sv
// trap_pkg: exception codes, privilege encodings and FSM states for the trap sequencer.
package trap_pkg;
    localparam logic [3:0] EXC_INST_MISALIGN  = 4'd0;
    localparam logic [3:0] EXC_ILLEGAL        = 4'd2;
    localparam logic [3:0] EXC_BREAK          = 4'd3;
    localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_ECALL_U        = 4'd8;
    localparam logic [3:0] EXC_ECALL_M        = 4'd11;
    localparam logic [1:0] UMODE = 2'b00;
    localparam logic [1:0] MMODE = 2'b11;
    typedef enum logic [1:0] {IDLE, TRAP, TRET, REDIR} state_t;
endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: retire-stage inputs and CSR/redirect outputs of the trap sequencer.
interface trap_ctrl_if #(parameter int XLEN = 32, parameter int CNT_W = 16);
    logic             inst_valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  inst;
    logic             exc_inst_misaligned;
    logic             exc_illegal;
    logic             exc_ebreak;
    logic             exc_ecall;
    logic             exc_load_misaligned;
    logic             exc_store_misaligned;
    logic [XLEN-1:0]  mem_addr;
    logic             mret_req;
    logic [1:0]       nowPrivMode;
    logic [XLEN-1:0]  mtvec_in;
    logic [XLEN-1:0]  mepc_cur;
    logic             exceptionFromInst;
    logic             mret;
    logic [3:0]       mcause;
    logic [XLEN-1:0]  mepc_out;
    logic [XLEN-1:0]  mtval;
    logic             stall;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] trap_count;

    modport master (
        output inst_valid, pc, inst, exc_inst_misaligned, exc_illegal, exc_ebreak, exc_ecall,
               exc_load_misaligned, exc_store_misaligned, mem_addr, mret_req, nowPrivMode,
               mtvec_in, mepc_cur,
        input  exceptionFromInst, mret, mcause, mepc_out, mtval, stall, redirect, redirect_pc,
               trap_count
    );
    modport slave (
        input  inst_valid, pc, inst, exc_inst_misaligned, exc_illegal, exc_ebreak, exc_ecall,
               exc_load_misaligned, exc_store_misaligned, mem_addr, mret_req, nowPrivMode,
               mtvec_in, mepc_cur,
        output exceptionFromInst, mret, mcause, mepc_out, mtval, stall, redirect, redirect_pc,
               trap_count
    );
endinterface

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: folds the exception flags of one instruction into a single cause and trap value.
module trap_prio_enc import trap_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            i_inst_misaligned,
    input  logic            i_illegal,
    input  logic            i_ebreak,
    input  logic            i_ecall,
    input  logic            i_load_misaligned,
    input  logic            i_store_misaligned,
    input  logic            i_mret,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_inst,
    input  logic [XLEN-1:0] i_mem_addr,
    input  logic [1:0]      i_priv,
    output logic            o_hit,
    output logic [3:0]      o_cause,
    output logic [XLEN-1:0] o_tval
);
    logic w_ill;
    // MRET outside M-mode is an illegal instruction, not a return
    assign w_ill = i_illegal | (i_mret & (i_priv != MMODE));
    assign o_hit = i_inst_misaligned | w_ill | i_ebreak | i_ecall | i_load_misaligned | i_store_misaligned;
    assign o_cause = i_inst_misaligned ? EXC_INST_MISALIGN :
                     w_ill             ? EXC_ILLEGAL :
                     i_ebreak          ? EXC_BREAK :
                     i_ecall           ? ((i_priv == MMODE) ? EXC_ECALL_M : EXC_ECALL_U) :
                     i_load_misaligned ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN;
    assign o_tval = i_inst_misaligned ? i_pc :
                    w_ill             ? i_inst :
                    i_ebreak          ? i_pc :
                    i_ecall           ? '0 : i_mem_addr;
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences trap entry/return strobes to the CSR file, then redirects the PC.
module trap_ctrl import trap_pkg::*; #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input logic   clk,
    input logic   reset,
    trap_ctrl_if.slave bus
);
    state_t           r_state;
    logic             r_exc, r_mret, r_redirect;
    logic [3:0]       r_cause;
    logic [XLEN-1:0]  r_mepc, r_mtval, r_target;
    logic [CNT_W-1:0] r_count;
    logic             w_hit, w_det, w_ret;
    logic [3:0]       w_cause;
    logic [XLEN-1:0]  w_tval;

    trap_prio_enc #(.XLEN(XLEN)) u_enc (
        .i_inst_misaligned (bus.exc_inst_misaligned),
        .i_illegal         (bus.exc_illegal),
        .i_ebreak          (bus.exc_ebreak),
        .i_ecall           (bus.exc_ecall),
        .i_load_misaligned (bus.exc_load_misaligned),
        .i_store_misaligned(bus.exc_store_misaligned),
        .i_mret            (bus.mret_req),
        .i_pc              (bus.pc),
        .i_inst            (bus.inst),
        .i_mem_addr        (bus.mem_addr),
        .i_priv            (bus.nowPrivMode),
        .o_hit             (w_hit),
        .o_cause           (w_cause),
        .o_tval            (w_tval)
    );

    assign w_det = bus.inst_valid & w_hit;
    // a hit already covers U-mode MRET, so what remains is a legal M-mode return
    assign w_ret = bus.inst_valid & bus.mret_req & ~w_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_exc      <= 1'b0;
            r_mret     <= 1'b0;
            r_redirect <= 1'b0;
            r_cause    <= '0;
            r_mepc     <= '0;
            r_mtval    <= '0;
            r_target   <= '0;
            r_count    <= '0;
        end else begin
            r_exc      <= 1'b0;
            r_mret     <= 1'b0;
            r_redirect <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_det) begin
                        r_state <= TRAP;
                        r_exc   <= 1'b1;
                        r_cause <= w_cause;
                        r_mepc  <= bus.pc;
                        r_mtval <= w_tval;
                    end else if (w_ret) begin
                        r_state <= TRET;
                        r_mret  <= 1'b1;
                    end
                end
                TRAP: begin
                    r_state    <= REDIR;
                    r_redirect <= 1'b1;
                    r_target   <= bus.mtvec_in & ~XLEN'(3);
                    if (r_count != '1) r_count <= r_count + 1'b1;
                end
                TRET: begin
                    r_state    <= REDIR;
                    r_redirect <= 1'b1;
                    r_target   <= bus.mepc_cur;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.exceptionFromInst = r_exc;
    assign bus.mret              = r_mret;
    assign bus.mcause            = r_cause;
    assign bus.mepc_out          = r_mepc;
    assign bus.mtval             = r_mtval;
    assign bus.redirect          = r_redirect;
    assign bus.redirect_pc       = r_target;
    assign bus.trap_count        = r_count;
    assign bus.stall             = (r_state != IDLE) | w_det | w_ret;
endmodule
